// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with a per-register scoreboard.
// Issue marks a destination busy; writeback stores data and clears busy.
// Reads are combinational with write-through bypass and x0 hardwired to zero.
module regfile_sb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NREAD = 2,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREAD*AW-1:0]          rd_addr,
  output logic [NREAD*XLEN-1:0]        rd_data,
  output logic [NREAD-1:0]             rd_busy,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [XLEN-1:0]              wr_data,
  input  logic                         issue_en,
  input  logic [AW-1:0]                issue_rd,
  input  logic                         flush,
  output logic [NREGS-1:0]             busy_vec,
  output logic [$clog2(NREGS+1)-1:0]   busy_cnt
);

  localparam int unsigned CW = $clog2(NREGS+1);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    rd_a;

  // Data storage: reset clears everything, writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Busy next-state: flush beats issue, issue beats a same-cycle writeback.
  always_comb begin
    busy_d    = busy_q;
    busy_d[0] = 1'b0;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int unsigned r = 1; r < NREGS; r++) begin
        if (issue_en && (issue_rd == AW'(r))) begin
          busy_d[r] = 1'b1;
        end else if (wr_en && (wr_addr == AW'(r))) begin
          busy_d[r] = 1'b0;
        end
      end
    end
  end

  // Count is derived from the next busy vector so it can never drift from it.
  always_comb begin
    cnt_d = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      cnt_d = cnt_d + CW'(busy_d[r]);
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Read ports: x0 reads zero, a same-cycle writeback bypasses the array.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_a    = '0;
    for (int unsigned k = 0; k < NREAD; k++) begin
      rd_a = rd_addr[k*AW +: AW];
      if (rd_a != '0) begin
        if (wr_en && (wr_addr == rd_a)) begin
          rd_data[k*XLEN +: XLEN] = wr_data;
        end else begin
          rd_data[k*XLEN +: XLEN] = regs_q[rd_a];
          rd_busy[k]              = busy_q[rd_a];
        end
      end
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default 2-port/32-bit instance plus a
// 4-port/64-bit instance for the wide simultaneous-read case.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default configuration
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        flush;
  logic [31:0] busy_vec;
  logic [5:0]  busy_cnt;

  regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush),
    .busy_vec(busy_vec), .busy_cnt(busy_cnt)
  );

  // Wide configuration
  logic         rst4_n;
  logic [19:0]  r4_addr;
  logic [255:0] r4_data;
  logic [3:0]   r4_busy;
  logic         w4_en;
  logic [4:0]   w4_addr;
  logic [63:0]  w4_data;
  logic         i4_en;
  logic [4:0]   i4_rd;
  logic         f4;
  logic [31:0]  b4_vec;
  logic [5:0]   b4_cnt;

  regfile_sb #(.XLEN(64), .NREGS(32), .NREAD(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .rd_addr(r4_addr), .rd_data(r4_data),
    .rd_busy(r4_busy), .wr_en(w4_en), .wr_addr(w4_addr), .wr_data(w4_data),
    .issue_en(i4_en), .issue_rd(i4_rd), .flush(f4),
    .busy_vec(b4_vec), .busy_cnt(b4_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_rd = '0; flush = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF_0000;
    issue_en = 1'b1; issue_rd = 5'd4;
    tick();
    rst_n = 1'b1;
    idle();
    checks++;
    if (busy_cnt !== 6'd0) begin
      errors++; $display("FAIL reset_cnt got %0d want 0", busy_cnt);
    end
    checks++;
    if (busy_vec !== 32'd0) begin
      errors++; $display("FAIL reset_vec got %h want 0", busy_vec);
    end
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a)};
      #1;
      checks++;
      if (rd_data !== 64'd0 || rd_busy !== 2'b00) begin
        errors++;
        $display("FAIL reset_read a=%0d got data %h busy %b want 0/00", a, rd_data, rd_busy);
      end
    end
  endtask

  task automatic test_issue_write;
    issue_en = 1'b1; issue_rd = 5'd5;
    tick();
    idle();
    checks++;
    if (busy_vec[5] !== 1'b1 || busy_cnt !== 6'd1) begin
      errors++; $display("FAIL issue5 got vec5 %b cnt %0d want 1/1", busy_vec[5], busy_cnt);
    end
    rd_addr = {5'd0, 5'd5};
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1) begin
      errors++; $display("FAIL issue5_rdbusy got %b want 1", rd_busy[0]);
    end
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    rd_addr = {5'd5, 5'd5};
    #1;
    checks++;
    if (rd_data !== {32'hDEAD_BEEF, 32'hDEAD_BEEF} || rd_busy !== 2'b00) begin
      errors++; $display("FAIL bypass got %h busy %b want deadbeef x2 / 00", rd_data, rd_busy);
    end
    tick();
    idle();
    #1;
    checks++;
    if (busy_cnt !== 6'd0 || rd_data[31:0] !== 32'hDEAD_BEEF || rd_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL wb5 got cnt %0d data %h busy %b want 0/deadbeef/0", busy_cnt, rd_data[31:0], rd_busy[0]);
    end
  endtask

  task automatic test_issue_wins;
    issue_en = 1'b1; issue_rd = 5'd7;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234;
    tick();
    idle();
    rd_addr = {5'd0, 5'd7};
    #1;
    checks++;
    if (busy_vec[7] !== 1'b1 || busy_cnt !== 6'd1) begin
      errors++; $display("FAIL issue_wins_busy got vec7 %b cnt %0d want 1/1", busy_vec[7], busy_cnt);
    end
    checks++;
    if (rd_data[31:0] !== 32'h1234 || rd_busy[0] !== 1'b1) begin
      errors++; $display("FAIL issue_wins_data got %h busy %b want 1234/1", rd_data[31:0], rd_busy[0]);
    end
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234;
    tick();
    idle();
    checks++;
    if (busy_cnt !== 6'd0) begin
      errors++; $display("FAIL clear7 got cnt %0d want 0", busy_cnt);
    end
  endtask

  task automatic test_net_zero;
    issue_en = 1'b1; issue_rd = 5'd12;
    tick();
    issue_rd = 5'd11;
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h00C0_FFEE;
    tick();
    idle();
    checks++;
    if (busy_cnt !== 6'd1 || busy_vec[12:11] !== 2'b01) begin
      errors++; $display("FAIL net_zero got cnt %0d vec %b want 1/01", busy_cnt, busy_vec[12:11]);
    end
    wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'h11;
    tick();
    idle();
    checks++;
    if (busy_cnt !== 6'd0) begin
      errors++; $display("FAIL net_zero_clear got cnt %0d want 0", busy_cnt);
    end
  endtask

  task automatic test_flush;
    for (int r = 1; r <= 3; r++) begin
      issue_en = 1'b1; issue_rd = 5'(r);
      tick();
    end
    idle();
    checks++;
    if (busy_cnt !== 6'd3 || busy_vec !== 32'h0000_000E) begin
      errors++; $display("FAIL pre_flush got cnt %0d vec %h want 3/0000000e", busy_cnt, busy_vec);
    end
    flush = 1'b1;
    issue_en = 1'b1; issue_rd = 5'd4;
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hA5A5_A5A5;
    tick();
    idle();
    rd_addr = {5'd4, 5'd2};
    #1;
    checks++;
    if (busy_cnt !== 6'd0 || busy_vec !== 32'd0) begin
      errors++; $display("FAIL flush got cnt %0d vec %h want 0/0", busy_cnt, busy_vec);
    end
    checks++;
    if (rd_data[31:0] !== 32'hA5A5_A5A5 || rd_busy !== 2'b00) begin
      errors++; $display("FAIL flush_wb got %h busy %b want a5a5a5a5/00", rd_data[31:0], rd_busy);
    end
  endtask

  task automatic test_x0;
    issue_en = 1'b1; issue_rd = 5'd10;
    tick();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    issue_en = 1'b1; issue_rd = 5'd0;
    rd_addr = {5'd0, 5'd0};
    #1;
    checks++;
    if (rd_data !== 64'd0 || rd_busy !== 2'b00) begin
      errors++; $display("FAIL x0_bypass got %h busy %b want 0/00", rd_data, rd_busy);
    end
    tick();
    idle();
    #1;
    checks++;
    if (busy_cnt !== 6'd1 || busy_vec[0] !== 1'b0 || rd_data !== 64'd0) begin
      errors++; $display("FAIL x0 got cnt %0d vec0 %b data %h want 1/0/0", busy_cnt, busy_vec[0], rd_data);
    end
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h10;
    tick();
    idle();
  endtask

  task automatic test_reset_mid;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
    tick();
    idle();
    issue_en = 1'b1; issue_rd = 5'd9;
    tick();
    idle();
    rd_addr = {5'd0, 5'd9};
    #1;
    checks++;
    if (rd_data[31:0] !== 32'h55 || rd_busy[0] !== 1'b1 || busy_cnt !== 6'd1) begin
      errors++; $display("FAIL pre_rst got %h busy %b cnt %0d want 55/1/1", rd_data[31:0], rd_busy[0], busy_cnt);
    end
    rst_n = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h77;
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    checks++;
    if (rd_data[31:0] !== 32'd0 || rd_busy[0] !== 1'b0 || busy_cnt !== 6'd0 || busy_vec !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid got %h busy %b cnt %0d vec %h want 0/0/0/0", rd_data[31:0], rd_busy[0], busy_cnt, busy_vec);
    end
  endtask

  task automatic test_wide;
    logic [63:0] vals [4];
    vals[0] = 64'h0123_4567_89AB_CDEF;
    vals[1] = 64'hFEDC_BA98_7654_3210;
    vals[2] = 64'hDEAD_BEEF_CAFE_F00D;
    vals[3] = 64'h8000_0000_0000_0001;
    rst4_n = 1'b0;
    w4_en = 1'b0; w4_addr = '0; w4_data = '0; i4_en = 1'b0; i4_rd = '0; f4 = 1'b0;
    r4_addr = '0;
    tick();
    rst4_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w4_en = 1'b1; w4_addr = 5'(i + 1); w4_data = vals[i];
      tick();
    end
    w4_en = 1'b0;
    i4_en = 1'b1; i4_rd = 5'd3;
    tick();
    i4_en = 1'b0;
    r4_addr = {5'd4, 5'd3, 5'd2, 5'd1};
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (r4_data[k*64 +: 64] !== vals[k]) begin
        errors++; $display("FAIL wide_read port %0d got %h want %h", k, r4_data[k*64 +: 64], vals[k]);
      end
    end
    checks++;
    if (r4_busy !== 4'b0100 || b4_cnt !== 6'd1) begin
      errors++; $display("FAIL wide_busy got %b cnt %0d want 0100/1", r4_busy, b4_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b1; rd_addr = '0; idle();
    rst4_n = 1'b1; r4_addr = '0;
    w4_en = 1'b0; w4_addr = '0; w4_data = '0; i4_en = 1'b0; i4_rd = '0; f4 = 1'b0;
    test_reset();
    test_issue_write();
    test_issue_wins();
    test_net_zero();
    test_flush();
    test_x0();
    test_reset_mid();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-read-port CPU register file with an integrated per-register scoreboard (busy bits).
- Sits between decode/issue and writeback in the pipelined core.
- Issue marks a destination register pending; writeback stores the data and clears the pending bit.
- Read ports return data plus a busy flag, so hazard logic can stall without a separate scoreboard.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >= 2)
NREAD, 2, number of combinational read ports (1..4)
AW, $clog2(NREGS), register address width (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
rd_addr  in  NREAD*AW  packed read addresses, port k at bits [k*AW +: AW]
rd_data  out  NREAD*XLEN  packed read data, port k at [k*XLEN +: XLEN]
rd_busy  out  NREAD  port k source register has a pending producer
wr_en  in  1  writeback valid
wr_addr  in  AW  writeback destination
wr_data  in  XLEN  writeback data
issue_en  in  1  an instruction with a destination register issues this cycle
issue_rd  in  AW  destination of the issuing instruction
flush  in  1  squash all in-flight producers
busy_vec  out  NREGS  registered busy bit per register
busy_cnt  out  $clog2(NREGS+1)  registered count of set busy bits

Behaviour:
- Reset, on a posedge with rst_n=0:
  - all registers and busy bits go to 0; busy_cnt goes to 0.
  - wr_en, issue_en and flush are ignored that cycle.
  - All outputs read 0 on the cycle after reset.
- Register 0:
  - reads always return 0 with rd_busy=0.
  - writes to address 0 are dropped; issue to address 0 never sets a busy bit.
- Write: when wr_en=1 and wr_addr!=0, regs[wr_addr] <= wr_data at posedge.
  - A write to a register that is not busy is legal and simply updates it.
- Read path (combinational, zero latency), per port k with address a=rd_addr[k]:
  - a==0: rd_data=0, rd_busy=0.
  - else if wr_en && wr_addr==a: rd_data=wr_data (write-through bypass), rd_busy=0.
  - else: rd_data=regs[a], rd_busy=busy[a].
  - Reads reflect state before this cycle's issue. The issuing instruction's own sources see the old value and old busy (e.g. x1 <- x1+x2 reads x1 unaffected by its own issue).
- Busy update per register r at posedge, in priority order:
  1. flush=1: busy[r] <= 0 for all r, and issue_en is ignored. A writeback in the same cycle still writes data.
  2. issue_en && issue_rd==r && r!=0: busy[r] <= 1. Issue wins over a same-cycle writeback to r, because a new producer supersedes the old one.
  3. wr_en && wr_addr==r: busy[r] <= 0.
  4. otherwise hold.
- busy_vec is the busy register array directly.
- busy_cnt is registered and always equals popcount(busy_vec). It is updated the same edge as the busy bits, so net +1, 0 or -1 per cycle, or 0 after flush. It never exceeds NREGS-1.
- No internal stall. The issuing stage must not issue while any of its sources report rd_busy=1. Re-issuing to an already-busy register is legal and leaves the bit set.
- Reset mid-operation: a reset cycle overrides all concurrent write, issue and flush; pending state is lost.

Test Plan:
1. Reset, then read all 32 addresses on both ports -> every rd_data=0, rd_busy=0, busy_cnt=0.
2. issue_en, issue_rd=5 -> next cycle busy_vec[5]=1, busy_cnt=1, a port reading 5 shows rd_busy=1. Then wr_en, wr_addr=5, wr_data=32'hDEADBEEF with rd_addr=5 in the same cycle -> that cycle rd_data=32'hDEADBEEF, rd_busy=0. Next cycle busy_cnt=0 and a read returns 32'hDEADBEEF.
3. Same-cycle issue_rd=7 and wr_addr=7 with wr_data=32'h1234 -> regs[7]=32'h1234 and busy[7] stays 1; busy_cnt increments by 1.
4. Issue to registers 1, 2 and 3 on consecutive cycles (busy_cnt=3). Then flush together with issue_rd=4 and wr_en to 2 with 32'hA5A5A5A5 -> busy_vec=0, busy_cnt=0, regs[2]=32'hA5A5A5A5, busy[4]=0.
5. wr_en, wr_addr=0, wr_data=32'hFFFFFFFF plus issue_rd=0 -> reading x0 gives 0 with rd_busy=0; busy_cnt is unchanged.
6. Load regs[9]=32'h55, issue_rd=9, then assert rst_n=0 together with wr_en to 9 -> next cycle reading 9 gives 0, busy_cnt=0. Also run NREAD=4 and XLEN=64 with 4 distinct simultaneous reads returning correct values.
